rv32imc_rvfi_monitor: RTL and testbench
=======================================

Name: rv32imc_rvfi_monitor

Overview:
Multi-channel RVFI commit-stream checker for the RV32IMC out-of-order core; sits in the verification harness beside the core's retirement ports. It checks up to NRET retirements per cycle for ordering, PC continuity, register-read consistency against a shadow register file, memory-mask legality, trap and halt rules. It reports the first violation as a sticky 16-bit error code.

Parameters:
NRET, 8, retirement channels per cycle
XLEN, 32, data/address width
ILEN, 32, instruction width

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-low
rvfi_valid  in  NRET  per-channel retirement valid
rvfi_order  in  64*NRET  retirement sequence number
rvfi_insn  in  ILEN*NRET  instruction word
rvfi_trap  in  NRET  trap flag
rvfi_halt  in  NRET  halt flag
rvfi_intr  in  NRET  interrupt flag (ignored)
rvfi_mode  in  2*NRET  privilege mode (ignored)
rvfi_rs1_addr / rvfi_rs2_addr  in  5*NRET  source register indices
rvfi_rs1_rdata / rvfi_rs2_rdata  in  XLEN*NRET  source values
rvfi_rd_addr  in  5*NRET  destination index
rvfi_rd_wdata  in  XLEN*NRET  destination value
rvfi_pc_rdata / rvfi_pc_wdata  in  XLEN*NRET  PC of the instruction / next PC
rvfi_mem_addr  in  XLEN*NRET  word-aligned memory address
rvfi_mem_rmask / rvfi_mem_wmask  in  4*NRET  byte read/write masks
rvfi_mem_rdata / rvfi_mem_wdata  in  XLEN*NRET  memory data
rvfi_mem_extamo  in  NRET  ignored
errcode  out  16  0 = no error; otherwise the first error code

Behaviour:
- Channel c occupies bits [c*W +: W] of each packed bus.
- All state updates on rising clock. While reset is low: errcode=0, expected order=0, pc-known flag=0, halted flag=0, all shadow registers invalid.
- Each cycle, valid channels are processed in ascending index order. Invalid channels are skipped; gaps between valid channels are allowed.
- Later channels in the same cycle see the effects of earlier channels: shadow writes, expected order, last pc_wdata and the halted flag.
- Checks per valid retirement, evaluated in this priority order:
  - 0x0108: halted flag already set.
  - 0x0107: trap=1.
  - 0x0101: order != expected order.
  - 0x0102: pc-known and pc_rdata != previous retirement's pc_wdata.
  - 0x0103: rs1_addr!=0, shadow[rs1] valid, rs1_rdata != shadow value.
  - 0x0104: same check for rs2.
  - 0x0105: rd_addr==0 and rd_wdata!=0.
  - 0x0106: a nonzero rmask or wmask not in {0001,0010,0100,1000,0011,1100,1111}, or rmask and wmask both nonzero.
- rs1/rs2 with address 0 are never checked; their rdata is don't-care.
- After checking a retirement:
  - expected order = order+1; this resynchronises even after 0x0101.
  - last pc = pc_wdata; pc-known=1.
  - if rd_addr!=0: shadow[rd]=rd_wdata, marked valid.
  - if halt=1: halted flag set.
- A valid retirement with halt=1 is legal when the halted flag is clear; any later valid retirement flags 0x0108.
- errcode is registered, so a violation appears one cycle after the offending edge.
- errcode is sticky: the first nonzero code (lowest channel, highest priority) is held until reset. Later errors do not overwrite it.
- Simultaneous errors on several channels in one cycle: the lowest channel index wins.
- Reset asserted mid-stream clears all state, including errcode, on the same edge.
- Order arithmetic is 64-bit and wraps naturally.
- Compressed instructions (insn[1:0]!=2'b11) are not decoded; PC continuity relies solely on pc_wdata.

Test Plan:
- Reset; retire orders 0..7 on all 8 channels in one cycle with chained PCs 0x60000000+4k -> errcode stays 0.
- Channel 0: order 0, rd x5=0x1234. Next cycle channel 0: order 1, rs1=x5, rs1_rdata=0x1235 -> errcode=0x0103 one cycle later; stays set across further clean cycles.
- Same cycle: channel 2 writes x3=0xA, channel 5 reads rs2=x3=0xA -> no error (intra-cycle forwarding). With 0xB instead -> 0x0104.
- Order sequence 0,1,3 -> 0x0101. pc_wdata 0x100 followed by pc_rdata 0x108 -> 0x0102.
- Channel 1: wmask 0110 -> 0x0106. Channel 0: rd_addr 0, wdata 5, in the same cycle -> errcode=0x0105 (lowest channel wins).
- Retirement with halt=1, then any valid retirement the next cycle -> 0x0108. Assert reset -> errcode=0 on the next edge; order 0 accepted again.

Source files
------------

// File: rtl/rv32imc_rvfi_monitor.sv
// RVFI commit-stream checker: ordering, PC continuity, shadow register file,
// memory mask legality, trap and halt rules across NRET retirement channels.

module rv32imc_rvfi_chan_chk #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_rmask,
    input  logic [3:0]      i_wmask,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_wdata,
    output logic            o_mask_bad,
    output logic            o_rd0_bad
);
    // Legal byte lanes: single byte, aligned halfword, or full word.
    function automatic logic mask_ok(input logic [3:0] m);
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
            default:                   mask_ok = 1'b0;
        endcase
    endfunction

    assign o_mask_bad = !mask_ok(i_rmask) || !mask_ok(i_wmask) ||
                        ((i_rmask != 4'b0000) && (i_wmask != 4'b0000));
    assign o_rd0_bad  = (i_rd_addr == 5'd0) && (i_rd_wdata != '0);
endmodule

module rv32imc_rvfi_monitor #(
    parameter int NRET = 8,
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [ILEN*NRET-1:0] rvfi_insn,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [NRET-1:0]      rvfi_intr,
    input  logic [2*NRET-1:0]    rvfi_mode,
    input  logic [5*NRET-1:0]    rvfi_rs1_addr,
    input  logic [5*NRET-1:0]    rvfi_rs2_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
    input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
    input  logic [XLEN*NRET-1:0] rvfi_mem_addr,
    input  logic [4*NRET-1:0]    rvfi_mem_rmask,
    input  logic [4*NRET-1:0]    rvfi_mem_wmask,
    input  logic [XLEN*NRET-1:0] rvfi_mem_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_mem_wdata,
    input  logic [NRET-1:0]      rvfi_mem_extamo,
    output logic [15:0]          errcode
);
    logic [63:0]             r_ord;
    logic [XLEN-1:0]         r_pc;
    logic                    r_pck;
    logic                    r_hlt;
    logic [31:0][XLEN-1:0]   r_sh;
    logic [31:0]             r_shv;
    logic [15:0]             r_err;

    logic [63:0]             w_ord;
    logic [XLEN-1:0]         w_pc;
    logic                    w_pck;
    logic                    w_hlt;
    logic [31:0][XLEN-1:0]   w_sh;
    logic [31:0]             w_shv;
    logic [15:0]             w_err;
    logic [15:0]             w_code;
    logic [4:0]              w_rs1a;
    logic [4:0]              w_rs2a;
    logic [4:0]              w_rda;
    logic [NRET-1:0]         w_mask_bad;
    logic [NRET-1:0]         w_rd0_bad;
    logic                    w_unused;

    assign w_unused = ^{rvfi_insn, rvfi_intr, rvfi_mode, rvfi_mem_addr,
                        rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo};

    // Order-independent checks are computed per lane in parallel.
    generate
        for (genvar g = 0; g < NRET; g++) begin : g_lane
            rv32imc_rvfi_chan_chk #(.XLEN(XLEN)) u_chk (
                .i_rmask    (rvfi_mem_rmask[g*4 +: 4]),
                .i_wmask    (rvfi_mem_wmask[g*4 +: 4]),
                .i_rd_addr  (rvfi_rd_addr[g*5 +: 5]),
                .i_rd_wdata (rvfi_rd_wdata[g*XLEN +: XLEN]),
                .o_mask_bad (w_mask_bad[g]),
                .o_rd0_bad  (w_rd0_bad[g])
            );
        end
    endgenerate

    // Channels are walked in index order so each one sees the state left by
    // the earlier valid channels of the same cycle.
    always_comb begin
        w_ord  = r_ord;
        w_pc   = r_pc;
        w_pck  = r_pck;
        w_hlt  = r_hlt;
        w_sh   = r_sh;
        w_shv  = r_shv;
        w_err  = 16'h0000;
        w_code = 16'h0000;
        w_rs1a = 5'd0;
        w_rs2a = 5'd0;
        w_rda  = 5'd0;
        for (int c = 0; c < NRET; c++) begin
            w_rs1a = rvfi_rs1_addr[c*5 +: 5];
            w_rs2a = rvfi_rs2_addr[c*5 +: 5];
            w_rda  = rvfi_rd_addr[c*5 +: 5];
            if (rvfi_valid[c]) begin
                if (w_hlt)
                    w_code = 16'h0108;
                else if (rvfi_trap[c])
                    w_code = 16'h0107;
                else if (rvfi_order[c*64 +: 64] != w_ord)
                    w_code = 16'h0101;
                else if (w_pck && (rvfi_pc_rdata[c*XLEN +: XLEN] != w_pc))
                    w_code = 16'h0102;
                else if ((w_rs1a != 5'd0) && w_shv[w_rs1a] &&
                         (rvfi_rs1_rdata[c*XLEN +: XLEN] != w_sh[w_rs1a]))
                    w_code = 16'h0103;
                else if ((w_rs2a != 5'd0) && w_shv[w_rs2a] &&
                         (rvfi_rs2_rdata[c*XLEN +: XLEN] != w_sh[w_rs2a]))
                    w_code = 16'h0104;
                else if (w_rd0_bad[c])
                    w_code = 16'h0105;
                else if (w_mask_bad[c])
                    w_code = 16'h0106;
                else
                    w_code = 16'h0000;
                if (w_err == 16'h0000)
                    w_err = w_code;
                // Always resync to the observed order so one slip reports once.
                w_ord = rvfi_order[c*64 +: 64] + 64'd1;
                w_pc  = rvfi_pc_wdata[c*XLEN +: XLEN];
                w_pck = 1'b1;
                if (w_rda != 5'd0) begin
                    w_sh[w_rda]  = rvfi_rd_wdata[c*XLEN +: XLEN];
                    w_shv[w_rda] = 1'b1;
                end
                if (rvfi_halt[c])
                    w_hlt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ord <= '0;
            r_pc  <= '0;
            r_pck <= 1'b0;
            r_hlt <= 1'b0;
            r_sh  <= '0;
            r_shv <= '0;
            r_err <= '0;
        end else begin
            r_ord <= w_ord;
            r_pc  <= w_pc;
            r_pck <= w_pck;
            r_hlt <= w_hlt;
            r_sh  <= w_sh;
            r_shv <= w_shv;
            if (r_err == 16'h0000)
                r_err <= w_err;
        end
    end

    assign errcode = r_err;
endmodule

// File: tb/tb_rv32imc_rvfi_monitor.sv
// Directed bench for the RVFI commit-stream monitor with hand-computed codes.

module tb_rv32imc_rvfi_monitor;
    localparam int NRET = 8;
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NRET-1:0]      valid, trap, halt, intr, extamo;
    logic [64*NRET-1:0]   order;
    logic [ILEN*NRET-1:0] insn;
    logic [2*NRET-1:0]    mode;
    logic [5*NRET-1:0]    rs1a, rs2a, rda;
    logic [XLEN*NRET-1:0] rs1d, rs2d, rdd, pcr, pcw, maddr, mrd, mwd;
    logic [4*NRET-1:0]    rmask, wmask;
    logic [15:0]          errcode;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    rv32imc_rvfi_monitor #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clock(clock), .reset(reset),
        .rvfi_valid(valid), .rvfi_order(order), .rvfi_insn(insn),
        .rvfi_trap(trap), .rvfi_halt(halt), .rvfi_intr(intr), .rvfi_mode(mode),
        .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a),
        .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d),
        .rvfi_rd_addr(rda), .rvfi_rd_wdata(rdd),
        .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw),
        .rvfi_mem_addr(maddr), .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
        .rvfi_mem_rdata(mrd), .rvfi_mem_wdata(mwd), .rvfi_mem_extamo(extamo),
        .errcode(errcode)
    );

    task automatic clr();
        valid = '0; trap = '0; halt = '0; intr = '0; extamo = '0;
        order = '0; insn = '0; mode = '0;
        rs1a = '0; rs2a = '0; rda = '0;
        rs1d = '0; rs2d = '0; rdd = '0; pcr = '0; pcw = '0;
        maddr = '0; mrd = '0; mwd = '0; rmask = '0; wmask = '0;
    endtask

    task automatic retire(input int c, input logic [63:0] o,
                          input logic [31:0] pr, input logic [31:0] pw);
        valid[c] = 1'b1;
        order[c*64 +: 64] = o;
        pcr[c*32 +: 32] = pr;
        pcw[c*32 +: 32] = pw;
        insn[c*32 +: 32] = 32'h00000013;
    endtask

    task automatic set_rd(input int c, input logic [4:0] a, input logic [31:0] d);
        rda[c*5 +: 5] = a;
        rdd[c*32 +: 32] = d;
    endtask

    task automatic set_rs1(input int c, input logic [4:0] a, input logic [31:0] d);
        rs1a[c*5 +: 5] = a;
        rs1d[c*32 +: 32] = d;
    endtask

    task automatic set_rs2(input int c, input logic [4:0] a, input logic [31:0] d);
        rs2a[c*5 +: 5] = a;
        rs2d[c*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr();
        step();
        reset = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        n_chk++;
        assert (errcode === exp) else begin
            n_fail++;
            $error("FAIL %s errcode=%h expected=%h", tag, errcode, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        clr();
        // Reset with garbage retirements present
        retire(0, 64'd9, 32'h1, 32'h2);
        trap[0] = 1'b1;
        step();
        step();
        chk("reset_state", 16'h0000);
        reset = 1'b1;

        // Full-width clean cycle with chained PCs, then a gapped channel
        for (int k = 0; k < NRET; k++)
            retire(k, 64'(k), 32'h60000000 + 32'(4*k), 32'h60000004 + 32'(4*k));
        step();
        chk("clean_8wide", 16'h0000);
        retire(3, 64'd8, 32'h60000020, 32'h60000024);
        step();
        chk("clean_gap", 16'h0000);

        // rs1 mismatch against shadow, then stickiness
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        set_rd(0, 5'd5, 32'h1234);
        set_rs1(0, 5'd7, 32'hDEAD);
        step();
        chk("rd_write_unread_rs", 16'h0000);
        retire(0, 64'd1, 32'h4, 32'h8);
        set_rs1(0, 5'd5, 32'h1235);
        step();
        chk("rs1_mismatch", 16'h0103);
        retire(0, 64'd2, 32'h8, 32'hC);
        step();
        chk("sticky_clean", 16'h0103);
        retire(0, 64'd3, 32'hC, 32'h10);
        trap[0] = 1'b1;
        step();
        chk("sticky_other_err", 16'h0103);

        // Intra-cycle forwarding of rd to a later channel's rs2
        do_reset();
        retire(2, 64'd0, 32'h0, 32'h4);
        set_rd(2, 5'd3, 32'hA);
        retire(5, 64'd1, 32'h4, 32'h8);
        set_rs2(5, 5'd3, 32'hA);
        set_rs1(5, 5'd0, 32'hDEADBEEF);
        step();
        chk("fwd_rs2_ok", 16'h0000);
        retire(2, 64'd2, 32'h8, 32'hC);
        set_rd(2, 5'd3, 32'h7);
        retire(5, 64'd3, 32'hC, 32'h10);
        set_rs2(5, 5'd3, 32'hA);
        step();
        chk("fwd_rs2_stale", 16'h0104);

        // Order gap
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        retire(1, 64'd1, 32'h4, 32'h8);
        step();
        chk("order_ok", 16'h0000);
        retire(0, 64'd3, 32'h8, 32'hC);
        step();
        chk("order_skip", 16'h0101);

        // PC discontinuity across cycles
        do_reset();
        retire(0, 64'd0, 32'h50, 32'h100);
        step();
        chk("pc_first_free", 16'h0000);
        retire(0, 64'd1, 32'h108, 32'h10C);
        step();
        chk("pc_break", 16'h0102);

        // Legal masks
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        rmask[0*4 +: 4] = 4'b0011;
        retire(1, 64'd1, 32'h4, 32'h8);
        wmask[1*4 +: 4] = 4'b1100;
        retire(2, 64'd2, 32'h8, 32'hC);
        wmask[2*4 +: 4] = 4'b1111;
        retire(3, 64'd3, 32'hC, 32'h10);
        rmask[3*4 +: 4] = 4'b1000;
        step();
        chk("mask_legal", 16'h0000);

        // rmask and wmask both set
        retire(0, 64'd4, 32'h10, 32'h14);
        rmask[0*4 +: 4] = 4'b0001;
        wmask[0*4 +: 4] = 4'b0001;
        step();
        chk("mask_rw_both", 16'h0106);

        // Illegal mask alone, then lowest channel wins
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        retire(1, 64'd1, 32'h4, 32'h8);
        wmask[1*4 +: 4] = 4'b0110;
        step();
        chk("mask_bad", 16'h0106);
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        set_rd(0, 5'd0, 32'h5);
        retire(1, 64'd1, 32'h4, 32'h8);
        wmask[1*4 +: 4] = 4'b0110;
        step();
        chk("lowest_chan_wins", 16'h0105);

        // Trap beats an order error on the same retirement
        do_reset();
        retire(0, 64'd4, 32'h0, 32'h4);
        trap[0] = 1'b1;
        step();
        chk("trap_prio", 16'h0107);

        // rs1 beats rs2 when both mismatch
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        set_rd(0, 5'd9, 32'h99);
        retire(1, 64'd1, 32'h4, 32'h8);
        set_rs1(1, 5'd9, 32'h1);
        set_rs2(1, 5'd9, 32'h2);
        step();
        chk("rs1_over_rs2", 16'h0103);

        // Halt within one cycle
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        halt[0] = 1'b1;
        retire(1, 64'd1, 32'h4, 32'h8);
        step();
        chk("halt_same_cycle", 16'h0108);

        // Halt, then retirement next cycle; reset mid-stream
        do_reset();
        retire(0, 64'd0, 32'h0, 32'h4);
        halt[0] = 1'b1;
        step();
        chk("halt_legal", 16'h0000);
        retire(0, 64'd1, 32'h4, 32'h8);
        trap[0] = 1'b1;
        step();
        chk("after_halt", 16'h0108);
        reset = 1'b0;
        retire(0, 64'd7, 32'h40, 32'h44);
        trap[0] = 1'b1;
        step();
        chk("mid_reset", 16'h0000);
        reset = 1'b1;
        retire(0, 64'd0, 32'h200, 32'h204);
        step();
        chk("post_reset_order0", 16'h0000);
        retire(0, 64'd1, 32'h204, 32'h208);
        step();
        chk("post_reset_next", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
